down_timer: RTL and testbench
=============================

# down_timer

Programmable, prescaled down-counting timer: the counterpart to the team's free-running 2-bit up counter. Software or an FSM loads a start value; the block counts down to zero at a programmable tick rate, pulses a terminal-count strobe, then either stops (one-shot) or reloads and repeats (auto-reload). It provides the timeouts, delays and periodic strobes used by the control blocks in the same design.

## Interface
- WIDTH, 8, width of count and load value
- PRE_WIDTH, 4, width of prescale field
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  reset, asynchronous, active-high; clock clk
- load  in  1  load load_val into count and reload register
- load_val  in  WIDTH  value captured by load
- prescale  in  PRE_WIDTH  tick divider; one decrement every prescale+1 RUN cycles
- auto_reload  in  1  1 = periodic, 0 = one-shot; sampled on each terminal tick
- start  in  1  enter/resume RUN
- stop  in  1  freeze in HOLD
- count  out  WIDTH  current count, registered
- busy  out  1  high when state is RUN, registered
- tc  out  1  terminal-count pulse, one cycle, registered

## Operation
- Reset: state IDLE, count=0, reload_reg=0, pre_cnt=0, busy=0, tc=0.
- States:
  - IDLE: stopped; count is held.
  - RUN: counting.
  - HOLD: paused; count and pre_cnt are frozen.
- Command priority when asserted in the same cycle: load > stop > start.
- load, any state:
  - reload_reg<=load_val, count<=load_val, pre_cnt<=0.
  - State is unchanged, except that load_val==0 while in RUN forces IDLE with no tc.
- start from IDLE:
  - If count!=0: enter RUN with pre_cnt<=0.
  - Else if reload_reg!=0: count<=reload_reg, then enter RUN.
  - Else: ignored.
- start from HOLD: resume RUN with pre_cnt retained. start while in RUN: no effect.
- stop in RUN: go to HOLD. stop in IDLE or HOLD: no effect.
- RUN tick: occurs when pre_cnt>=prescale; pre_cnt resets to 0 on a tick and otherwise increments. Using >= keeps behaviour safe when prescale is lowered mid-run.
- On a tick:
  - count>1: count<=count-1.
  - count==1: count<=0 and tc<=1. If auto_reload==0, state<=IDLE in the same edge.
  - count==0 (auto-reload only): count<=reload_reg, no tc.
- Arithmetic: count never underflows; it decrements only when count>=1. Auto-reload period is reload_reg+1 ticks.
- tc is high only in the single cycle after the 1->0 transition; it is cleared on all other edges.

## Timing
- busy rises on the edge that captures start and falls on the edge where one-shot count reaches 0. In one-shot mode, tc=1 and busy=0 appear in the same cycle.
- Tick spacing is prescale+1 cycles. With prescale=0, count decrements every RUN cycle, starting on the edge after RUN entry.
- Reset asserted mid-count: all outputs go to their reset values immediately (asynchronous). The first RUN requires a new load or start after reset deasserts.
- load during HOLD: the new count is held; a subsequent start resumes with the new count and the retained pre_cnt.
- A prescale change takes effect at the next compare; no intermediate tick is lost or duplicated.

## Test plan
- One-shot, prescale=0: load 3, then start.
  - count is 3,2,1,0 on successive edges.
  - tc=1 and busy=0 exactly in the count=0 cycle.
  - tc=0 afterwards; count holds at 0.
- Prescale: prescale=2, load 2, start.
  - Decrements occur every 3 cycles.
  - tc is asserted 6 cycles after RUN entry.
- Auto-reload: load 2, auto_reload=1, start.
  - count sequence is 2,1,0,2,1,0...
  - tc fires once per 3 ticks; busy stays 1.
- Stop/resume: stop asserted at count=5 with prescale=3 and pre_cnt=1.
  - Count and pre_cnt stay frozen for 10 cycles.
  - After start, the next decrement occurs 3 cycles later.
- Priority and edge cases:
  - load, start and stop asserted together in IDLE: count=load_val and state is IDLE.
  - start with reload_reg=0 and count=0: ignored.
  - load 0 in RUN: IDLE, no tc.
- Async reset mid-run at count=7: count=0, busy=0 and tc=0 before the next clk edge.

Source files
------------

// File: rtl/down_timer.sv
// Prescaled down-counting timer with one-shot and auto-reload modes.
// Commands resolve load > stop > start; tc pulses for one cycle after each 1->0 step.
module down_timer #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned PRE_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic [WIDTH-1:0]     load_val,
  input  logic [PRE_WIDTH-1:0] prescale,
  input  logic                 auto_reload,
  input  logic                 start,
  input  logic                 stop,
  output logic [WIDTH-1:0]     count,
  output logic                 busy,
  output logic                 tc
);

  typedef enum logic [1:0] {StIdle, StRun, StHold} state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     count_q, count_d;
  logic [WIDTH-1:0]     reload_q, reload_d;
  logic [PRE_WIDTH-1:0] pre_cnt_q, pre_cnt_d;
  logic                 tc_q, tc_d;
  logic                 tick;

  // >= rather than == so lowering prescale mid-run cannot skip past the compare.
  assign tick = (pre_cnt_q >= prescale);

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    reload_d  = reload_q;
    pre_cnt_d = pre_cnt_q;
    tc_d      = 1'b0;

    if (load) begin
      reload_d  = load_val;
      count_d   = load_val;
      pre_cnt_d = '0;
      if (state_q == StRun && load_val == '0) begin
        state_d = StIdle;
      end
    end else if (stop && state_q != StIdle) begin
      state_d = StHold;
    end else if (start && state_q == StIdle) begin
      if (count_q != '0) begin
        state_d   = StRun;
        pre_cnt_d = '0;
      end else if (reload_q != '0) begin
        count_d   = reload_q;
        state_d   = StRun;
        pre_cnt_d = '0;
      end
    end else if (start && state_q == StHold) begin
      state_d = StRun;
    end else if (state_q == StRun) begin
      if (tick) begin
        pre_cnt_d = '0;
        if (count_q > WIDTH'(1)) begin
          count_d = count_q - WIDTH'(1);
        end else if (count_q == WIDTH'(1)) begin
          count_d = '0;
          tc_d    = 1'b1;
          if (!auto_reload) begin
            state_d = StIdle;
          end
        end else if (auto_reload) begin
          count_d = reload_q;
        end else begin
          state_d = StIdle;
        end
      end else begin
        pre_cnt_d = pre_cnt_q + PRE_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      count_q   <= '0;
      reload_q  <= '0;
      pre_cnt_q <= '0;
      tc_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      reload_q  <= reload_d;
      pre_cnt_q <= pre_cnt_d;
      tc_q      <= tc_d;
    end
  end

  assign count = count_q;
  assign busy  = (state_q == StRun);
  assign tc    = tc_q;

endmodule

// File: tb/tb_down_timer.sv
// Scenario bench for down_timer: hand-derived per-cycle expectations queued per scenario
// and popped one per clock edge.
module tb_down_timer;

  logic       clk;
  logic       reset;
  logic       load;
  logic [7:0] load_val;
  logic [3:0] prescale;
  logic       auto_reload;
  logic       start;
  logic       stop;
  logic [7:0] count;
  logic       busy;
  logic       tc;

  typedef struct packed {
    logic [7:0] count;
    logic       busy;
    logic       tc;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;

  down_timer #(
    .WIDTH    (8),
    .PRE_WIDTH(4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .load_val   (load_val),
    .prescale   (prescale),
    .auto_reload(auto_reload),
    .start      (start),
    .stop       (stop),
    .count      (count),
    .busy       (busy),
    .tc         (tc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [7:0] c, input logic b, input logic t);
    exp_t r;
    r.count = c;
    r.busy  = b;
    r.tc    = t;
    return r;
  endfunction

  task automatic test_reset();
    @(posedge clk);
    #1;
    checks++;
    if ({count, busy, tc} !== {8'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset: count=%0d busy=%b tc=%b, expected count=0 busy=0 tc=0",
               count, busy, tc);
    end
    reset = 1'b0;
    sb.push_back(mk(8'd0, 1'b0, 1'b0));
    while (sb.size() != 0) begin
      @(posedge clk);
      #1;
      e = sb.pop_front();
      checks++;
      if ({count, busy, tc} !== e) begin
        errors++;
        $display("FAIL reset_idle: count=%0d busy=%b tc=%b, expected count=%0d busy=%b tc=%b",
                 count, busy, tc, e.count, e.busy, e.tc);
      end
    end
  endtask

  // Drives a one-cycle command pulse, then checks every queued cycle.
  task automatic test_oneshot();
    prescale    = 4'd0;
    auto_reload = 1'b0;
    load        = 1'b1;
    load_val    = 8'd3;
    sb.push_back(mk(8'd3, 1'b0, 1'b0));
    for (int phase = 0; phase < 2; phase++) begin
      if (phase == 1) begin
        start = 1'b1;
        sb.push_back(mk(8'd3, 1'b1, 1'b0));
        sb.push_back(mk(8'd2, 1'b1, 1'b0));
        sb.push_back(mk(8'd1, 1'b1, 1'b0));
        sb.push_back(mk(8'd0, 1'b0, 1'b1));
        sb.push_back(mk(8'd0, 1'b0, 1'b0));
        sb.push_back(mk(8'd0, 1'b0, 1'b0));
      end
      while (sb.size() != 0) begin
        @(posedge clk);
        #1;
        {load, start, stop} = 3'b000;
        e = sb.pop_front();
        checks++;
        if ({count, busy, tc} !== e) begin
          errors++;
          $display("FAIL oneshot: count=%0d busy=%b tc=%b, expected count=%0d busy=%b tc=%b",
                   count, busy, tc, e.count, e.busy, e.tc);
        end
      end
    end
  endtask

  task automatic test_prescale();
    prescale = 4'd2;
    load     = 1'b1;
    load_val = 8'd2;
    sb.push_back(mk(8'd2, 1'b0, 1'b0));
    for (int phase = 0; phase < 2; phase++) begin
      if (phase == 1) begin
        start = 1'b1;
        for (int i = 0; i < 3; i++) sb.push_back(mk(8'd2, 1'b1, 1'b0));
        for (int i = 0; i < 3; i++) sb.push_back(mk(8'd1, 1'b1, 1'b0));
        sb.push_back(mk(8'd0, 1'b0, 1'b1));
        sb.push_back(mk(8'd0, 1'b0, 1'b0));
      end
      while (sb.size() != 0) begin
        @(posedge clk);
        #1;
        {load, start, stop} = 3'b000;
        e = sb.pop_front();
        checks++;
        if ({count, busy, tc} !== e) begin
          errors++;
          $display("FAIL prescale: count=%0d busy=%b tc=%b, expected count=%0d busy=%b tc=%b",
                   count, busy, tc, e.count, e.busy, e.tc);
        end
      end
    end
  endtask

  // Ends with load 0 while running, which must drop to IDLE with no tc.
  task automatic test_auto_reload();
    prescale    = 4'd0;
    auto_reload = 1'b1;
    load        = 1'b1;
    load_val    = 8'd2;
    sb.push_back(mk(8'd2, 1'b0, 1'b0));
    for (int phase = 0; phase < 3; phase++) begin
      if (phase == 1) begin
        start = 1'b1;
        sb.push_back(mk(8'd2, 1'b1, 1'b0));
        for (int k = 0; k < 2; k++) begin
          sb.push_back(mk(8'd1, 1'b1, 1'b0));
          sb.push_back(mk(8'd0, 1'b1, 1'b1));
          sb.push_back(mk(8'd2, 1'b1, 1'b0));
        end
      end else if (phase == 2) begin
        load     = 1'b1;
        load_val = 8'd0;
        sb.push_back(mk(8'd0, 1'b0, 1'b0));
        sb.push_back(mk(8'd0, 1'b0, 1'b0));
      end
      while (sb.size() != 0) begin
        @(posedge clk);
        #1;
        {load, start, stop} = 3'b000;
        e = sb.pop_front();
        checks++;
        if ({count, busy, tc} !== e) begin
          errors++;
          $display("FAIL auto_reload: count=%0d busy=%b tc=%b, expected count=%0d busy=%b tc=%b",
                   count, busy, tc, e.count, e.busy, e.tc);
        end
      end
    end
    auto_reload = 1'b0;
  endtask

  task automatic test_stop_resume();
    prescale = 4'd3;
    load     = 1'b1;
    load_val = 8'd6;
    sb.push_back(mk(8'd6, 1'b0, 1'b0));
    for (int phase = 0; phase < 5; phase++) begin
      case (phase)
        1: begin
          // Leaves count=5 with pre_cnt=1 when the drain ends.
          start = 1'b1;
          for (int i = 0; i < 4; i++) sb.push_back(mk(8'd6, 1'b1, 1'b0));
          sb.push_back(mk(8'd5, 1'b1, 1'b0));
          sb.push_back(mk(8'd5, 1'b1, 1'b0));
        end
        2: begin
          stop = 1'b1;
          for (int i = 0; i < 10; i++) sb.push_back(mk(8'd5, 1'b0, 1'b0));
        end
        3: begin
          start = 1'b1;
          for (int i = 0; i < 3; i++) sb.push_back(mk(8'd5, 1'b1, 1'b0));
          sb.push_back(mk(8'd4, 1'b1, 1'b0));
        end
        4: begin
          load     = 1'b1;
          load_val = 8'd0;
          sb.push_back(mk(8'd0, 1'b0, 1'b0));
        end
        default: ;
      endcase
      while (sb.size() != 0) begin
        @(posedge clk);
        #1;
        {load, start, stop} = 3'b000;
        e = sb.pop_front();
        checks++;
        if ({count, busy, tc} !== e) begin
          errors++;
          $display("FAIL stop_resume: count=%0d busy=%b tc=%b, expected count=%0d busy=%b tc=%b",
                   count, busy, tc, e.count, e.busy, e.tc);
        end
      end
    end
  endtask

  // Entered with count=0 and reload_reg=0 in IDLE.
  task automatic test_priority();
    prescale = 4'd0;
    start    = 1'b1;
    sb.push_back(mk(8'd0, 1'b0, 1'b0));
    sb.push_back(mk(8'd0, 1'b0, 1'b0));
    for (int phase = 0; phase < 5; phase++) begin
      case (phase)
        1: begin
          {load, start, stop} = 3'b111;
          load_val = 8'd9;
          sb.push_back(mk(8'd9, 1'b0, 1'b0));
          sb.push_back(mk(8'd9, 1'b0, 1'b0));
        end
        2: begin
          load     = 1'b1;
          load_val = 8'd1;
          sb.push_back(mk(8'd1, 1'b0, 1'b0));
        end
        3, 4: begin
          // Second start restarts from reload_reg because count is already 0.
          start = 1'b1;
          sb.push_back(mk(8'd1, 1'b1, 1'b0));
          sb.push_back(mk(8'd0, 1'b0, 1'b1));
          sb.push_back(mk(8'd0, 1'b0, 1'b0));
        end
        default: ;
      endcase
      while (sb.size() != 0) begin
        @(posedge clk);
        #1;
        {load, start, stop} = 3'b000;
        e = sb.pop_front();
        checks++;
        if ({count, busy, tc} !== e) begin
          errors++;
          $display("FAIL priority: count=%0d busy=%b tc=%b, expected count=%0d busy=%b tc=%b",
                   count, busy, tc, e.count, e.busy, e.tc);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    prescale = 4'd0;
    load     = 1'b1;
    load_val = 8'd9;
    sb.push_back(mk(8'd9, 1'b0, 1'b0));
    for (int phase = 0; phase < 2; phase++) begin
      if (phase == 1) begin
        start = 1'b1;
        sb.push_back(mk(8'd9, 1'b1, 1'b0));
        sb.push_back(mk(8'd8, 1'b1, 1'b0));
        sb.push_back(mk(8'd7, 1'b1, 1'b0));
      end
      while (sb.size() != 0) begin
        @(posedge clk);
        #1;
        {load, start, stop} = 3'b000;
        e = sb.pop_front();
        checks++;
        if ({count, busy, tc} !== e) begin
          errors++;
          $display("FAIL async_reset_run: count=%0d busy=%b tc=%b, expected count=%0d busy=%b tc=%b",
                   count, busy, tc, e.count, e.busy, e.tc);
        end
      end
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({count, busy, tc} !== {8'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL async_reset: count=%0d busy=%b tc=%b, expected count=0 busy=0 tc=0",
               count, busy, tc);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    sb.push_back(mk(8'd0, 1'b0, 1'b0));
    sb.push_back(mk(8'd0, 1'b0, 1'b0));
    while (sb.size() != 0) begin
      @(posedge clk);
      #1;
      e = sb.pop_front();
      checks++;
      if ({count, busy, tc} !== e) begin
        errors++;
        $display("FAIL after_reset: count=%0d busy=%b tc=%b, expected count=%0d busy=%b tc=%b",
                 count, busy, tc, e.count, e.busy, e.tc);
      end
    end
  endtask

  initial begin
    reset       = 1'b1;
    load        = 1'b0;
    load_val    = 8'd0;
    prescale    = 4'd0;
    auto_reload = 1'b0;
    start       = 1'b0;
    stop        = 1'b0;
    test_reset();
    test_oneshot();
    test_prescale();
    test_auto_reload();
    test_stop_resume();
    test_priority();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
